// File: rtl/spi_controller.sv
// ============================================================================
// Module   : spi_controller
// Function : Mode-0 SPI initiator. Sends one 16-bit register-access frame per
//            request and captures the final 8 CIPO bits of the frame.
// Revision : 1.0
// ============================================================================
`default_nettype none

module spi_controller #(
  parameter int CLK_DIV      = 4,
  parameter int SETUP_CYCLES = 2,
  parameter int HOLD_CYCLES  = 2,
  parameter int GAP_CYCLES   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       busy,
  output logic       sCLK,
  output logic       nCS,
  output logic       COPI,
  input  logic       CIPO
);

  localparam int c_MAX_A = (CLK_DIV > SETUP_CYCLES) ? CLK_DIV : SETUP_CYCLES;
  localparam int c_MAX_B = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int c_MAX   = (c_MAX_A > c_MAX_B) ? c_MAX_A : c_MAX_B;
  localparam int c_CW    = $clog2(c_MAX);

  localparam logic [c_CW-1:0] c_DIV_LAST   = c_CW'(CLK_DIV - 1);
  localparam logic [c_CW-1:0] c_SETUP_LAST = c_CW'(SETUP_CYCLES - 1);
  localparam logic [c_CW-1:0] c_HOLD_LAST  = c_CW'(HOLD_CYCLES - 1);
  localparam logic [c_CW-1:0] c_GAP_LAST   = c_CW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  state_t            r_state,    w_state;
  logic [c_CW-1:0]   r_cnt,      w_cnt;
  logic [4:0]        r_bit,      w_bit;
  logic [15:0]       r_shreg,    w_shreg;
  logic              r_sclk,     w_sclk;
  logic              r_ncs,      w_ncs;
  logic [7:0]        r_rx,       w_rx;
  logic [7:0]        r_rd_data,  w_rd_data;
  logic              r_rd_valid, w_rd_valid;
  logic [1:0]        r_cipo_sync;
  logic              w_accept;

  assign w_accept = req_valid && (r_state == ST_IDLE);

  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_bit      = r_bit;
    w_shreg    = r_shreg;
    w_sclk     = r_sclk;
    w_ncs      = r_ncs;
    w_rx       = r_rx;
    w_rd_data  = r_rd_data;
    w_rd_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state = ST_SETUP;
          w_cnt   = '0;
          w_shreg = {req_rw, req_addr, req_wdata};
          w_ncs   = 1'b0;
          w_sclk  = 1'b0;
        end
      end
      ST_SETUP: begin
        if (r_cnt == c_SETUP_LAST) begin
          w_state = ST_SHIFT;
          w_cnt   = '0;
          w_bit   = 5'd0;
          w_sclk  = 1'b1;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      ST_SHIFT: begin
        if (r_cnt == c_DIV_LAST) begin
          w_cnt = '0;
          if (r_sclk) begin
            // Falling edge: sample CIPO, advance COPI; zero-fill leaves COPI=0 after bit 0
            w_sclk  = 1'b0;
            w_shreg = {r_shreg[14:0], 1'b0};
            w_bit   = r_bit + 1'b1;
            w_rx    = {r_rx[6:0], r_cipo_sync[1]};
          end else if (r_bit == 5'd16) begin
            w_state = ST_HOLD;
          end else begin
            w_sclk = 1'b1;
          end
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      ST_HOLD: begin
        if (r_cnt == c_HOLD_LAST) begin
          w_state    = ST_GAP;
          w_cnt      = '0;
          w_ncs      = 1'b1;
          w_rd_data  = r_rx;
          w_rd_valid = 1'b1;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      ST_GAP: begin
        if (r_cnt == c_GAP_LAST) begin
          w_state = ST_IDLE;
          w_cnt   = '0;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state = ST_IDLE;
        w_cnt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_shreg     <= '0;
      r_sclk      <= 1'b0;
      r_ncs       <= 1'b1;
      r_rx        <= '0;
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
      r_cipo_sync <= '0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_bit       <= w_bit;
      r_shreg     <= w_shreg;
      r_sclk      <= w_sclk;
      r_ncs       <= w_ncs;
      r_rx        <= w_rx;
      r_rd_data   <= w_rd_data;
      r_rd_valid  <= w_rd_valid;
      r_cipo_sync <= {r_cipo_sync[0], CIPO};
    end
  end

  // Pins come straight from flops so peripherals never see glitches
  assign sCLK      = r_sclk;
  assign nCS       = r_ncs;
  assign COPI      = r_shreg[15];
  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;
  assign busy      = (r_state != ST_IDLE);
  assign req_ready = (r_state == ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_spi_controller.sv
// ============================================================================
// Module   : tb_spi_controller
// Function : Self-checking bench for spi_controller (default and swept params).
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_spi_controller;

  localparam int SW_SETUP = 1;
  localparam int SW_HOLD  = 3;
  localparam int SW_GAP   = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       req_valid = 1'b0, valid_a = 1'b0, valid_b = 1'b0;
  logic       req_rw = 1'b0;
  logic [6:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       cipo = 1'b0;

  wire       req_ready, rd_valid, busy, sclk, ncs, copi;
  wire [7:0] rd_data;
  wire       ready_a, rdv_a, busy_a, sclk_a, ncs_a, copi_a;
  wire [7:0] rdd_a;
  wire       ready_b, rdv_b, busy_b, sclk_b, ncs_b, copi_b;
  wire [7:0] rdd_b;

  spi_controller dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
    .sCLK(sclk), .nCS(ncs), .COPI(copi), .CIPO(cipo)
  );

  spi_controller #(.CLK_DIV(4), .SETUP_CYCLES(SW_SETUP), .HOLD_CYCLES(SW_HOLD), .GAP_CYCLES(SW_GAP)) dut_a (
    .clk(clk), .rst(rst), .req_valid(valid_a), .req_ready(ready_a),
    .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
    .rd_data(rdd_a), .rd_valid(rdv_a), .busy(busy_a),
    .sCLK(sclk_a), .nCS(ncs_a), .COPI(copi_a), .CIPO(cipo)
  );

  spi_controller #(.CLK_DIV(7), .SETUP_CYCLES(SW_SETUP), .HOLD_CYCLES(SW_HOLD), .GAP_CYCLES(SW_GAP)) dut_b (
    .clk(clk), .rst(rst), .req_valid(valid_b), .req_ready(ready_b),
    .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
    .rd_data(rdd_b), .rd_valid(rdv_b), .busy(busy_b),
    .sCLK(sclk_b), .nCS(ncs_b), .COPI(copi_b), .CIPO(cipo)
  );

  logic sweep_sel = 1'b0;
  wire  s_sclk  = sweep_sel ? sclk_b  : sclk_a;
  wire  s_ncs   = sweep_sel ? ncs_b   : ncs_a;
  wire  s_ready = sweep_sel ? ready_b : ready_a;

  typedef struct {
    logic [15:0] word;
    logic [7:0]  rd;
  } exp_t;

  typedef struct {
    logic [15:0] word;
    int          rises;
    int          fall_cyc;
    int          rise_cyc;
    logic [7:0]  rd;
    logic        rv;
  } obs_t;

  exp_t exp_q[$];
  obs_t obs_q[$];

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int rv_total = 0;
  logic [7:0] cipo_byte = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  // Frame monitor on the default instance
  logic        m_ncs_prev = 1'b1, m_sclk_prev = 1'b0;
  logic [15:0] m_word = '0;
  int          m_rises = 0, m_fall = 0;
  always @(negedge clk) begin
    obs_t o;
    if (rst) begin
      m_ncs_prev  = 1'b1;
      m_sclk_prev = 1'b0;
      m_rises     = 0;
    end else begin
      if (rd_valid) rv_total++;
      if (!ncs && m_ncs_prev) begin
        m_fall  = cyc;
        m_rises = 0;
        m_word  = '0;
      end
      if (!ncs && sclk && !m_sclk_prev) begin
        m_word = {m_word[14:0], copi};
        m_rises++;
      end
      if (ncs && !m_ncs_prev) begin
        o.word = m_word; o.rises = m_rises; o.fall_cyc = m_fall;
        o.rise_cyc = cyc; o.rd = rd_data; o.rv = rd_valid;
        obs_q.push_back(o);
      end
      m_ncs_prev  = ncs;
      m_sclk_prev = sclk;
    end
  end

  // Peripheral model: presents cipo_byte MSB first, changing on sCLK falls 8..15
  logic c_sclk_prev = 1'b0;
  int   c_falls = 0;
  always @(negedge clk) begin
    if (rst || ncs) begin
      c_falls = 0;
      cipo    = 1'b0;
    end else if (!sclk && c_sclk_prev) begin
      c_falls++;
      if (c_falls >= 8 && c_falls <= 15) cipo = cipo_byte[15 - c_falls];
    end
    c_sclk_prev = sclk;
  end

  task automatic send(input logic rw, input logic [6:0] a, input logic [7:0] d);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 500) begin @(negedge clk); n++; end
    if (!req_ready) begin
      vectors++; errors++;
      $display("FAIL send_ready_timeout: req_ready=%b want 1", req_ready);
    end
    req_rw = rw; req_addr = a; req_wdata = d; req_valid = 1'b1;
    e.word = {rw, a, d}; e.rd = cipo_byte;
    exp_q.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic get_obs(output obs_t o, output bit ok);
    int n = 0;
    while (obs_q.size() == 0 && n < 1000) begin @(posedge clk); n++; end
    ok = (obs_q.size() != 0);
    o  = '{default: 0};
    if (!ok) begin
      vectors++; errors++;
      $display("FAIL frame_timeout: no nCS rise within %0d cycles", n);
    end else begin
      o = obs_q.pop_front();
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors += 7;
    if (ncs !== 1'b1)       begin errors++; $display("FAIL reset_ncs: got %b want 1", ncs); end
    if (sclk !== 1'b0)      begin errors++; $display("FAIL reset_sclk: got %b want 0", sclk); end
    if (copi !== 1'b0)      begin errors++; $display("FAIL reset_copi: got %b want 0", copi); end
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (rd_valid !== 1'b0)  begin errors++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
    if (rd_data !== 8'h00)  begin errors++; $display("FAIL reset_rd_data: got %h want 00", rd_data); end
  endtask

  task automatic test_write;
    obs_t o; exp_t e; bit ok; int rv0;
    cipo_byte = 8'h5A;
    rv0 = rv_total;
    send(1'b1, 7'h04, 8'hA5);
    get_obs(o, ok);
    e = exp_q.pop_front();
    if (ok) begin
      vectors += 5;
      if (o.word !== e.word || e.word !== 16'h84A5)
        begin errors++; $display("FAIL write_frame: got %h want %h", o.word, 16'h84A5); end
      if (o.rises != 16) begin errors++; $display("FAIL write_rises: got %0d want 16", o.rises); end
      if (o.rise_cyc - o.fall_cyc != 132)
        begin errors++; $display("FAIL write_ncs_low: got %0d want 132", o.rise_cyc - o.fall_cyc); end
      if (o.rd !== e.rd) begin errors++; $display("FAIL write_rd_data: got %h want %h", o.rd, e.rd); end
      if (o.rv !== 1'b1) begin errors++; $display("FAIL write_rd_valid: got %b want 1", o.rv); end
      do @(negedge clk); while (!req_ready && (cyc - o.rise_cyc) < 20);
      vectors++;
      if (cyc - o.rise_cyc != 4)
        begin errors++; $display("FAIL write_ready_latency: got %0d want 4", cyc - o.rise_cyc); end
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (rv_total - rv0 != 1) begin errors++; $display("FAIL write_rv_count: got %0d want 1", rv_total - rv0); end
  endtask

  task automatic test_read;
    obs_t o; exp_t e; bit ok; int rv0;
    cipo_byte = 8'h3C;
    rv0 = rv_total;
    send(1'b0, 7'h01, 8'h77);
    get_obs(o, ok);
    e = exp_q.pop_front();
    if (ok) begin
      vectors += 4;
      if (o.word[15:8] !== 8'h01 || o.word !== e.word)
        begin errors++; $display("FAIL read_frame: got %h want %h", o.word, e.word); end
      if (o.rd !== 8'h3C) begin errors++; $display("FAIL read_rd_data: got %h want 3c", o.rd); end
      if (o.rv !== 1'b1) begin errors++; $display("FAIL read_rd_valid: got %b want 1", o.rv); end
      @(negedge clk);
      if (rd_valid !== 1'b0) begin errors++; $display("FAIL read_rv_width: got %b want 0", rd_valid); end
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (rv_total - rv0 != 1) begin errors++; $display("FAIL read_rv_count: got %0d want 1", rv_total - rv0); end
  endtask

  task automatic test_back_to_back;
    obs_t o1, o2; exp_t e1, e2; bit ok1, ok2; exp_t e;
    int n = 0;
    cipo_byte = 8'h11;
    @(negedge clk);
    while (!req_ready && n < 500) begin @(negedge clk); n++; end
    req_rw = 1'b1; req_addr = 7'h00; req_wdata = 8'hFF; req_valid = 1'b1;
    e.word = 16'h80FF; e.rd = cipo_byte; exp_q.push_back(e);
    @(posedge clk); #1;
    req_rw = 1'b1; req_addr = 7'h02; req_wdata = 8'h0F;
    e.word = 16'h820F; e.rd = cipo_byte; exp_q.push_back(e);
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready && n < 500);
    @(posedge clk); #1;
    req_valid = 1'b0;
    get_obs(o1, ok1);
    get_obs(o2, ok2);
    e1 = exp_q.pop_front();
    e2 = exp_q.pop_front();
    if (ok1 && ok2) begin
      vectors += 3;
      if (o1.word !== e1.word) begin errors++; $display("FAIL b2b_frame1: got %h want %h", o1.word, e1.word); end
      if (o2.word !== e2.word) begin errors++; $display("FAIL b2b_frame2: got %h want %h", o2.word, e2.word); end
      if (o2.fall_cyc - o1.rise_cyc != 5)
        begin errors++; $display("FAIL b2b_gap: got %0d want 5", o2.fall_cyc - o1.rise_cyc); end
    end
  endtask

  task automatic test_input_stability;
    obs_t o; exp_t e; bit ok;
    cipo_byte = 8'hE7;
    send(1'b1, 7'h55, 8'h3B);
    for (int i = 0; i < 140; i++) begin
      @(negedge clk);
      req_rw    = 1'($urandom);
      req_addr  = 7'($urandom);
      req_wdata = 8'($urandom);
    end
    get_obs(o, ok);
    e = exp_q.pop_front();
    if (ok) begin
      vectors += 2;
      if (o.word !== e.word) begin errors++; $display("FAIL stable_frame: got %h want %h", o.word, e.word); end
      if (o.rd !== e.rd)     begin errors++; $display("FAIL stable_rd_data: got %h want %h", o.rd, e.rd); end
    end
  endtask

  task automatic test_reset_mid_shift;
    obs_t o; exp_t e; bit ok;
    int r = 0, n = 0, rv0;
    logic prev = 1'b0;
    cipo_byte = 8'hC3;
    rv0 = rv_total;
    send(1'b1, 7'h10, 8'h33);
    while (r < 5 && n < 500) begin
      @(negedge clk);
      if (sclk && !prev) r++;
      prev = sclk;
      n++;
    end
    rst = 1'b1;
    #1;
    vectors += 6;
    if (ncs !== 1'b1)      begin errors++; $display("FAIL rstmid_ncs: got %b want 1", ncs); end
    if (sclk !== 1'b0)     begin errors++; $display("FAIL rstmid_sclk: got %b want 0", sclk); end
    if (copi !== 1'b0)     begin errors++; $display("FAIL rstmid_copi: got %b want 0", copi); end
    if (busy !== 1'b0)     begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    if (rd_data !== 8'h00) begin errors++; $display("FAIL rstmid_rd_data: got %h want 00", rd_data); end
    if (rd_valid !== 1'b0) begin errors++; $display("FAIL rstmid_rd_valid: got %b want 0", rd_valid); end
    e = exp_q.pop_front();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors += 3;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b want 1", req_ready); end
    if (obs_q.size() != 0)  begin errors++; $display("FAIL rstmid_no_frame: got %0d frames want 0", obs_q.size()); end
    if (rv_total != rv0)    begin errors++; $display("FAIL rstmid_no_rv: got %0d pulses want 0", rv_total - rv0); end
    cipo_byte = 8'h96;
    send(1'b1, 7'h7F, 8'h01);
    get_obs(o, ok);
    e = exp_q.pop_front();
    if (ok) begin
      vectors += 3;
      if (o.word !== e.word) begin errors++; $display("FAIL rstmid_new_frame: got %h want %h", o.word, e.word); end
      if (o.rd !== e.rd)     begin errors++; $display("FAIL rstmid_new_rd: got %h want %h", o.rd, e.rd); end
      if (o.rise_cyc - o.fall_cyc != 132)
        begin errors++; $display("FAIL rstmid_new_len: got %0d want 132", o.rise_cyc - o.fall_cyc); end
    end
  endtask

  task automatic test_param_sweep(input bit sel, input int div);
    int n = 0, fall = -1, rise = -1, first = -1, rises = 0, run = 0, badh = 0, badl = 0;
    logic prev = 1'b0;
    sweep_sel = sel;
    @(negedge clk);
    while (!s_ready && n < 500) begin @(negedge clk); n++; end
    if (sel) valid_b = 1'b1; else valid_a = 1'b1;
    @(posedge clk); #1;
    valid_a = 1'b0; valid_b = 1'b0;
    n = 0;
    while (rise < 0 && n < 2000) begin
      @(negedge clk);
      n++;
      if (fall < 0) begin
        if (!s_ncs) fall = cyc;
      end else if (s_ncs) begin
        rise = cyc;
      end
      if (fall >= 0 && rise < 0) begin
        if (s_sclk != prev) begin
          if (s_sclk) begin
            rises++;
            if (first < 0) first = cyc;
            else if (run != div) badl++;
          end else if (run != div) begin
            badh++;
          end
          run = 1;
        end else begin
          run++;
        end
        prev = s_sclk;
      end
    end
    vectors += 5;
    if (rise - fall != SW_SETUP + 32 * div + SW_HOLD)
      begin errors++; $display("FAIL sweep%0d_ncs_low: got %0d want %0d", div, rise - fall, SW_SETUP + 32 * div + SW_HOLD); end
    if (first - fall != SW_SETUP)
      begin errors++; $display("FAIL sweep%0d_setup: got %0d want %0d", div, first - fall, SW_SETUP); end
    if (rises != 16) begin errors++; $display("FAIL sweep%0d_rises: got %0d want 16", div, rises); end
    if (badh != 0)   begin errors++; $display("FAIL sweep%0d_high_half: got %0d bad want 0", div, badh); end
    if (badl != 0)   begin errors++; $display("FAIL sweep%0d_low_half: got %0d bad want 0", div, badl); end
    n = 0;
    while (!s_ready && n < 50) begin @(negedge clk); n++; end
    vectors++;
    if (cyc - rise != SW_GAP)
      begin errors++; $display("FAIL sweep%0d_gap: got %0d want %0d", div, cyc - rise, SW_GAP); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_input_stability();
    test_reset_mid_shift();
    test_param_sweep(1'b0, 4);
    test_param_sweep(1'b1, 7);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
